// File: rtl/fb_write_arbiter.sv
// Two-port frame buffer write arbiter: round-robin grant with bounded hold,
// burst lock, registered single write port and sticky out-of-range flag.
//
// state | meaning
// IDLE  | no grant; next request wins (tie goes to the port that is not last_owner)
// OWN0  | painter (port 0) owns the write port, gnt0 high
// OWN1  | overlay writer (port 1) owns the write port, gnt1 high
module fb_write_arbiter #(
    parameter int PIXEL_NUM       = 76800,
    parameter int PIXEL_NUM_WIDTH = $clog2(PIXEL_NUM),
    parameter int MAX_HOLD        = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req0,
    input  logic                       req1,
    input  logic                       lock0,
    input  logic                       lock1,
    input  logic                       we0,
    input  logic                       we1,
    input  logic [PIXEL_NUM_WIDTH-1:0] addr0,
    input  logic [PIXEL_NUM_WIDTH-1:0] addr1,
    input  logic                       data0,
    input  logic                       data1,
    output logic                       gnt0,
    output logic                       gnt1,
    output logic [PIXEL_NUM_WIDTH-1:0] ram_write_addr,
    output logic                       ram_data,
    output logic                       ram_write_en,
    output logic                       oob_err
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    // One extra bit so a power-of-two depth still compares correctly.
    localparam logic [PIXEL_NUM_WIDTH:0] PIX_LIMIT = (PIXEL_NUM_WIDTH + 1)'(PIXEL_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  last_owner, last_owner_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_cnt_nxt;
    logic                  in_range0, in_range1;
    logic                  wr0, wr1, oob0, oob1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            hold_cnt   <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        hold_cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt      = last_owner ? OWN0 : OWN1;
                    last_owner_nxt = ~last_owner;
                end else if (req0) begin
                    state_nxt      = OWN0;
                    last_owner_nxt = 1'b0;
                end else if (req1) begin
                    state_nxt      = OWN1;
                    last_owner_nxt = 1'b1;
                end
            end
            OWN0: begin
                if (!req0)
                    state_nxt = req1 ? OWN1 : IDLE;
                else if (!lock0 && req1 && hold_cnt == HOLD_LAST)
                    state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_nxt = req0 ? OWN0 : IDLE;
                else if (!lock1 && req0 && hold_cnt == HOLD_LAST)
                    state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase

        // Tenure restarts on every new owner, including direct handovers.
        if (state_nxt != IDLE && state_nxt != state)
            hold_cnt_nxt = '0;
        else if (state != IDLE && hold_cnt != HOLD_MAX)
            hold_cnt_nxt = hold_cnt + 1'b1;
    end

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    assign in_range0 = ({1'b0, addr0} < PIX_LIMIT);
    assign in_range1 = ({1'b0, addr1} < PIX_LIMIT);
    assign wr0  = gnt0 & we0 & in_range0;
    assign wr1  = gnt1 & we1 & in_range1;
    assign oob0 = gnt0 & we0 & ~in_range0;
    assign oob1 = gnt1 & we1 & ~in_range1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_write_en   <= 1'b0;
            ram_write_addr <= '0;
            ram_data       <= 1'b0;
            oob_err        <= 1'b0;
        end else begin
            ram_write_en <= wr0 | wr1;
            if (wr0) begin
                ram_write_addr <= addr0;
                ram_data       <= data0;
            end else if (wr1) begin
                ram_write_addr <= addr1;
                ram_data       <= data1;
            end
            if (oob0 | oob1)
                oob_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: directed vector table, multi-cycle corner
// sequences, and randomized traffic against an ownership-level reference model.
module tb_fb_write_arbiter;

    localparam int PIXEL_NUM = 76800;
    localparam int PW        = 17;
    localparam int MAX_HOLD  = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, lock0, lock1, we0, we1, data0, data1;
    logic [PW-1:0] addr0, addr1;
    logic          gnt0, gnt1, ram_data, ram_write_en, oob_err;
    logic [PW-1:0] ram_write_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .PIXEL_NUM      (PIXEL_NUM),
        .PIXEL_NUM_WIDTH(PW),
        .MAX_HOLD       (MAX_HOLD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req0          (req0),
        .req1          (req1),
        .lock0         (lock0),
        .lock1         (lock1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .data0         (data0),
        .data1         (data1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .ram_write_addr(ram_write_addr),
        .ram_data      (ram_data),
        .ram_write_en  (ram_write_en),
        .oob_err       (oob_err)
    );

    // Reference model: who owns the port, how long they have owned it,
    // and what the frame buffer write port last showed.
    int            m_owner;
    int            m_prev;
    int            m_tenure;
    logic          m_wen, m_data, m_oob;
    logic [PW-1:0] m_addr;

    function automatic void model_reset();
        m_owner  = -1;
        m_prev   = 1;
        m_tenure = 0;
        m_wen    = 1'b0;
        m_data   = 1'b0;
        m_oob    = 1'b0;
        m_addr   = '0;
    endfunction

    function automatic void model_step();
        logic          r[2], l[2], w[2], d[2];
        logic [PW-1:0] a[2];
        int            nxt;
        r[0] = req0;  r[1] = req1;
        l[0] = lock0; l[1] = lock1;
        w[0] = we0;   w[1] = we1;
        d[0] = data0; d[1] = data1;
        a[0] = addr0; a[1] = addr1;

        m_wen = 1'b0;
        if (m_owner >= 0 && w[m_owner]) begin
            if (int'(a[m_owner]) < PIXEL_NUM) begin
                m_wen  = 1'b1;
                m_addr = a[m_owner];
                m_data = d[m_owner];
            end else begin
                m_oob = 1'b1;
            end
        end

        if (m_owner < 0) begin
            if (r[0] && r[1]) nxt = 1 - m_prev;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
            else              nxt = -1;
            if (nxt >= 0) begin
                m_prev   = nxt;
                m_tenure = 0;
            end
        end else begin
            nxt = m_owner;
            if (!r[m_owner])
                nxt = r[1 - m_owner] ? 1 - m_owner : -1;
            else if (!l[m_owner] && r[1 - m_owner] && m_tenure == MAX_HOLD - 1)
                nxt = 1 - m_owner;
            if (nxt == m_owner) m_tenure++;
            else                m_tenure = 0;
        end
        m_owner = nxt;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {gnt0, gnt1, ram_write_en, ram_write_addr, ram_data, oob_err};
    endfunction

    function automatic logic [21:0] model_vec();
        return {m_owner == 0, m_owner == 1, m_wen, m_addr, m_data, m_oob};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        data0 = 0; data1 = 0; addr0 = '0; addr1 = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_model(input string name);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check(name, dut_vec(), model_vec());
    endtask

    typedef struct {
        logic [5:0]    ctl;   // req0 req1 lock0 lock1 we0 we1
        logic [PW-1:0] a0;
        logic [PW-1:0] a1;
        logic [1:0]    dat;   // data0 data1
        logic [2:0]    eg;    // gnt0 gnt1 ram_write_en
        logic [PW-1:0] ea;
        logic [1:0]    ed;    // ram_data oob_err
    } vec_t;

    vec_t tbl[10];

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int k;
        int bad;

        reset_n = 1'b0;
        clear_inputs();
        model_reset();

        tbl[0] = '{6'b110000, 17'd0,     17'd0,     2'b00, 3'b100, 17'd0,     2'b00};
        tbl[1] = '{6'b110010, 17'd76799, 17'd0,     2'b10, 3'b101, 17'd76799, 2'b10};
        tbl[2] = '{6'b010010, 17'd5,     17'd0,     2'b00, 3'b011, 17'd5,     2'b00};
        tbl[3] = '{6'b010010, 17'd7,     17'd0,     2'b10, 3'b010, 17'd5,     2'b00};
        tbl[4] = '{6'b010001, 17'd0,     17'd76800, 2'b01, 3'b010, 17'd5,     2'b01};
        tbl[5] = '{6'b010001, 17'd0,     17'd100,   2'b01, 3'b011, 17'd100,   2'b11};
        tbl[6] = '{6'b000000, 17'd0,     17'd0,     2'b00, 3'b000, 17'd100,   2'b11};
        tbl[7] = '{6'b110000, 17'd0,     17'd0,     2'b00, 3'b010, 17'd100,   2'b11};
        tbl[8] = '{6'b000000, 17'd0,     17'd0,     2'b00, 3'b000, 17'd100,   2'b11};
        tbl[9] = '{6'b100000, 17'd0,     17'd0,     2'b00, 3'b100, 17'd100,   2'b11};

        apply_reset();
        check("reset_state", dut_vec(), 22'd0);

        for (int i = 0; i < 10; i++) begin
            {req0, req1, lock0, lock1, we0, we1} = tbl[i].ctl;
            addr0 = tbl[i].a0;
            addr1 = tbl[i].a1;
            {data0, data1} = tbl[i].dat;
            step();
            check($sformatf("vec%0d", i), dut_vec(),
                  {tbl[i].eg, tbl[i].ea, tbl[i].ed});
        end

        // Sticky error is cleared only by reset.
        apply_reset();
        check("oob_cleared_by_reset", dut_vec(), 22'd0);

        // Unlocked pre-emption after MAX_HOLD cycles.
        req0 = 1'b1;
        step();
        check_int("preempt_gnt0_rise", int'(gnt0), 1);
        req1 = 1'b1;
        k = 0;
        while (!gnt1 && k < 40) begin
            step();
            k++;
        end
        check_int("preempt_latency", k, MAX_HOLD);
        check_int("preempt_gnt0_low", int'(gnt0), 0);

        // Locked burst is never split; handover right after req0 falls.
        apply_reset();
        req0  = 1'b1;
        lock0 = 1'b1;
        step();
        check_int("lock_gnt0_rise", int'(gnt0), 1);
        req1 = 1'b1;
        bad  = 0;
        for (int i = 0; i < 2000; i++) begin
            we0   = 1'b1;
            addr0 = 17'(i * 37 % PIXEL_NUM);
            data0 = i[0];
            step();
            if (!gnt0 || gnt1 || !ram_write_en ||
                ram_write_addr != 17'(i * 37 % PIXEL_NUM) || ram_data != i[0])
                bad++;
        end
        check_int("lock_no_preempt", bad, 0);
        req0 = 1'b0;
        we0  = 1'b0;
        step();
        check_int("lock_handover_gnt1", int'(gnt1), 1);
        check_int("lock_handover_gnt0", int'(gnt0), 0);

        // Asynchronous reset in the middle of a write burst.
        apply_reset();
        req0  = 1'b1;
        we0   = 1'b1;
        addr0 = 17'd10;
        data0 = 1'b1;
        step();
        step();
        check("midburst_active", dut_vec(), {3'b101, 17'd10, 2'b10});
        #2;
        reset_n = 1'b0;
        #1;
        check("midburst_async_clear", dut_vec(), 22'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        check("post_reset_first_edge", dut_vec(), {3'b100, 17'd0, 2'b00});
        step();
        check("post_reset_second_edge", dut_vec(), {3'b101, 17'd10, 2'b10});

        // Randomized traffic against the reference model.
        for (int seg = 0; seg < 2; seg++) begin
            apply_reset();
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(7) == 0)  req0  = ~req0;
                if ($urandom_range(7) == 0)  req1  = ~req1;
                if ($urandom_range(15) == 0) lock0 = ~lock0;
                if ($urandom_range(15) == 0) lock1 = ~lock1;
                we0   = 1'($urandom_range(1));
                we1   = 1'($urandom_range(1));
                data0 = 1'($urandom_range(1));
                data1 = 1'($urandom_range(1));
                addr0 = ($urandom_range(299) == 0) ? 17'(PIXEL_NUM + $urandom_range(30))
                                                   : 17'($urandom_range(PIXEL_NUM - 1));
                addr1 = ($urandom_range(299) == 0) ? 17'(PIXEL_NUM + $urandom_range(30))
                                                   : 17'($urandom_range(PIXEL_NUM - 1));
                step_model("random");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
